veririsc_sequencer: RTL and testbench



---
 rtl/veririsc_sequencer_if.sv | 32 +++
 rtl/veririsc_sequencer.sv | 145 ++++++++++++++
 tb/tb_veririsc_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/veririsc_sequencer_if.sv
// Datapath-facing bundle of the VeriRISC sequencer: IR/flag/memory-ready inputs
// and the decoded opcode plus datapath strobes.
interface veririsc_sequencer_if #(
  parameter int IR_WIDTH = 8
) ();
  // Memory handshake: rd is the read request and mem_ready its ready.
  // A read phase completes only on a cycle where rd & mem_ready are both high.
  // Until then the sequencer holds the phase and keeps rd asserted.
  logic [IR_WIDTH-1:0] ir_in;
  logic                zero;
  logic                mem_ready;
  logic [2:0]          opcode;
  logic                sel;
  logic                rd;
  logic                wr;
  logic                ld_ir;
  logic                ld_ac;
  logic                ld_pc;
  logic                inc_pc;
  logic                data_e;
  logic                halt;

  modport master (
    input  ir_in, zero, mem_ready,
    output opcode, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt
  );

  modport slave (
    output ir_in, zero, mem_ready,
    input  opcode, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt
  );
endinterface

// File: rtl/veririsc_sequencer.sv
// VeriRISC 8-phase instruction sequencer with memory stall, sticky halt,
// single-step pause and a retired-instruction counter.
module veririsc_sequencer #(
  parameter int IR_WIDTH  = 8,
  parameter int OPC_LSB   = 0,
  parameter int USE_READY = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  veririsc_sequencer_if.master bus,
  input  logic                 resume,
  input  logic                 step_mode,
  input  logic                 step,
  output logic [2:0]           phase,
  output logic                 halted,
  output logic                 paused,
  output logic [CNT_WIDTH-1:0] instr_count
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;
  localparam int OPC_MSB = (OPC_LSB + 2 < IR_WIDTH) ? OPC_LSB + 2 : IR_WIDTH - 1;
  localparam bit READY_EN = (USE_READY != 0);

  phase_e               ph_q, ph_d;
  logic                 halted_q, halted_d;
  logic                 paused_q, paused_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [2:0] opc;
  logic       alu_op;
  logic       stall;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q     <= INST_ADDR;
      halted_q <= 1'b0;
      paused_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ph_q     <= ph_d;
      halted_q <= halted_d;
      paused_q <= paused_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    ph_d     = ph_q;
    halted_d = halted_q;
    paused_d = paused_q;
    cnt_d    = cnt_q;
    sel      = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    ld_ir    = 1'b0;
    ld_ac    = 1'b0;
    ld_pc    = 1'b0;
    inc_pc   = 1'b0;
    data_e   = 1'b0;
    halt     = 1'b0;
    stall    = 1'b0;
    // The IR is only trustworthy once it has been loaded (IDLE onward).
    opc      = (ph_q >= IDLE) ? bus.ir_in[OPC_MSB -: 3] : 3'd0;
    alu_op   = (opc >= OP_ADD) && (opc <= OP_LDA);

    if (halted_q) begin
      halt = 1'b1;
      if (resume) halted_d = 1'b0;
    end else if (paused_q) begin
      if (step) paused_d = 1'b0;
    end else begin
      case (ph_q)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        OP_ADDR:    begin inc_pc = 1'b1; halt = (opc == OP_HLT); end
        OP_FETCH:   rd = alu_op;
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = (opc == OP_SKZ) && bus.zero;
          ld_pc  = (opc == OP_JMP);
          data_e = (opc == OP_STO);
        end
        default: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opc == OP_JMP);
          wr     = (opc == OP_STO);
          data_e = (opc == OP_STO);
        end
      endcase

      stall = READY_EN && rd && !bus.mem_ready;
      if (!stall) begin
        if (ph_q == OP_ADDR && opc == OP_HLT) begin
          // Park at OP_FETCH so resume continues the HLT instruction there.
          halted_d = 1'b1;
          ph_d     = OP_FETCH;
        end else if (ph_q == STORE) begin
          cnt_d    = cnt_q + CNT_WIDTH'(1);
          ph_d     = INST_ADDR;
          paused_d = step_mode;
        end else begin
          ph_d = phase_e'(ph_q + 3'd1);
        end
      end
    end
  end

  assign bus.opcode = opc;
  assign bus.sel    = sel;
  assign bus.rd     = rd;
  assign bus.wr     = wr;
  assign bus.ld_ir  = ld_ir;
  assign bus.ld_ac  = ld_ac;
  assign bus.ld_pc  = ld_pc;
  assign bus.inc_pc = inc_pc;
  assign bus.data_e = data_e;
  assign bus.halt   = halt;

  assign phase       = ph_q;
  assign halted      = halted_q;
  assign paused      = paused_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_veririsc_sequencer.sv
// Scoreboarded random/directed bench for veririsc_sequencer against a
// cycle-level behavioural model of the instruction cycle.
module tb_veririsc_sequencer;
  localparam int W = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        resume = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic [2:0]  phase;
  logic        halted, paused;
  logic [15:0] instr_count;

  veririsc_sequencer_if #(.IR_WIDTH(8)) bus ();

  veririsc_sequencer #(
    .IR_WIDTH(8), .OPC_LSB(0), .USE_READY(1), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .resume(resume), .step_mode(step_mode), .step(step),
    .phase(phase), .halted(halted), .paused(paused), .instr_count(instr_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  string        cur_test = "reset";
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] dut_vec;

  assign dut_vec = {phase, bus.opcode, bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac,
                    bus.ld_pc, bus.inc_pc, bus.data_e, bus.halt, halted, paused, instr_count};

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase;
  bit m_halted, m_paused;
  int m_count;

  task automatic model_reset();
    m_phase = 0; m_halted = 0; m_paused = 0; m_count = 0;
  endtask

  function automatic int eff_op(input logic [2:0] irop);
    return (m_phase >= 3) ? int'(irop) : 0;
  endfunction

  function automatic bit model_rd(input logic [2:0] irop);
    int op = eff_op(irop);
    bit alu = (op >= 2 && op <= 5);
    if (m_halted || m_paused) return 0;
    return (m_phase >= 1 && m_phase <= 3) || (m_phase >= 5 && alu);
  endfunction

  function automatic logic [W-1:0] model_expect(input logic [2:0] irop, input logic z);
    int op = eff_op(irop);
    bit alu = (op >= 2 && op <= 5);
    bit s = 0, r = 0, w = 0, li = 0, la = 0, lp = 0, ip = 0, de = 0, h = 0;
    if (m_halted) h = 1;
    else if (!m_paused) begin
      s  = (m_phase <= 3);
      r  = model_rd(irop);
      li = (m_phase == 2 || m_phase == 3);
      ip = (m_phase == 4) || (m_phase == 6 && op == 1 && z);
      h  = (m_phase == 4 && op == 0);
      la = (m_phase == 7 && alu);
      lp = (m_phase >= 6 && op == 7);
      w  = (m_phase == 7 && op == 6);
      de = (m_phase >= 6 && op == 6);
    end
    return {3'(m_phase), 3'(op), s, r, w, li, la, lp, ip, de, h, m_halted, m_paused, 16'(m_count)};
  endfunction

  task automatic model_step(input logic [2:0] irop, input logic mr, res, sm, st);
    if (m_halted) begin
      if (res) m_halted = 0;
    end else if (m_paused) begin
      if (st) m_paused = 0;
    end else if (!(model_rd(irop) && !mr)) begin
      if (m_phase == 4 && eff_op(irop) == 0) begin
        m_halted = 1; m_phase = 5;
      end else if (m_phase == 7) begin
        m_count = (m_count + 1) % 65536; m_phase = 0; m_paused = sm;
      end else m_phase++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [2:0] op, input logic z, mr, res, sm, st);
    logic [7:0] ir_v;
    ir_v = 8'($urandom);
    ir_v[2:0] = op;
    bus.ir_in = ir_v; bus.zero = z; bus.mem_ready = mr;
    resume = res; step_mode = sm; step = st;
    exp_q.push_back(model_expect(op, z));
    name_q.push_back(cur_test);
    model_step(op, mr, res, sm, st);
    @(negedge clk);
  endtask

  task automatic run(input logic [2:0] op, input logic z, input int n);
    for (int i = 0; i < n; i++) cycle(op, z, 1'b1, 1'b0, step_mode, 1'b0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_phase"}, W'(phase), W'(0));
    check({nm, "_flags"}, W'({halted, paused}), W'(0));
    check({nm, "_count"}, W'(instr_count), W'(0));
    check({nm, "_sel"}, W'(bus.sel), W'(1));
    check({nm, "_strobes"}, W'({bus.rd, bus.wr, bus.ld_ir, bus.ld_ac, bus.ld_pc,
                                bus.inc_pc, bus.data_e, bus.halt}), W'(0));
    check({nm, "_opcode"}, W'(bus.opcode), W'(0));
  endtask

  // Asserts reset between edges and checks the asynchronous effect.
  task automatic do_reset(input string nm);
    #3 rst = 1'b1;
    model_reset();
    #1 check_reset_outputs(nm);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    string nm;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, dut_vec, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic sm;
    bus.ir_in = 8'hE5; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    cur_test = "add";
    run(3'd2, 1'b0, 8);
    #1 check("add_count", W'(instr_count), W'(1));
    check("add_phase", W'(phase), W'(0));

    cur_test = "sto";   run(3'd6, 1'b0, 8);
    cur_test = "jmp";   run(3'd7, 1'b1, 8);
    cur_test = "skz_z1"; run(3'd1, 1'b1, 8);
    cur_test = "skz_z0"; run(3'd1, 1'b0, 8);

    cur_test = "stall";
    cycle(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("stall_hold_phase", W'(phase), W'(1));
    run(3'd2, 1'b0, 7);
    #1 check("stall_count", W'(instr_count), W'(6));
    check("stall_phase", W'(phase), W'(0));

    cur_test = "hlt";
    run(3'd0, 1'b0, 5);
    #1 check("hlt_halted", W'({halted, phase}), W'({1'b1, 3'd5}));
    run(3'd0, 1'b0, 10);
    cycle(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(3'd0, 1'b0, 3);
    #1 check("hlt_count", W'(instr_count), W'(7));
    check("hlt_released", W'({halted, phase}), W'(0));

    cur_test = "step";
    step_mode = 1'b1;
    run(3'd5, 1'b0, 8);
    #1 check("step_paused", W'({paused, bus.sel}), W'({1'b1, 1'b0}));
    run(3'd5, 1'b0, 3);
    cycle(3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run(3'd5, 1'b0, 8);
    #1 check("step_count", W'({paused, instr_count}), W'({1'b1, 16'd9}));
    run(3'd4, 1'b0, 2);
    do_reset("rst_in_pause");
    step_mode = 1'b0;

    cur_test = "random";
    sm = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (i % 40 == 0) sm = 1'($urandom_range(0, 1));
      cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
            sm, ($urandom_range(0, 6) == 0));
    end

    repeat (3) @(negedge clk);
    #3 check("drain", W'(exp_q.size()), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
